result_demux_1_to_2: RTL

//  Registered 1-to-2 demultiplexer for the 16-bit processor datapath; inverse of the 2-to-1 source mux.

---
 rtl/result_demux_1_to_2_if.sv | 38 +++
 rtl/result_demux_1_to_2.sv | 87 ++++++++
 2 files changed

// File: rtl/result_demux_1_to_2_if.sv
// Handshake bundle for result_demux_1_to_2: producer side plus two consumer channels.
// CountA/CountB exist only when DEMUX_COUNT_EN is defined.
interface result_demux_1_to_2_if #(
    parameter int unsigned WIDTH = 16
);
    logic             InValid;
    logic             InReady;
    logic             S;
    logic [WIDTH-1:0] D;
    logic             AValid;
    logic             AReady;
    logic [WIDTH-1:0] A;
    logic             BValid;
    logic             BReady;
    logic [WIDTH-1:0] B;
`ifdef DEMUX_COUNT_EN
    logic [WIDTH-1:0] CountA;
    logic [WIDTH-1:0] CountB;
`endif

    // Demux side
    modport slave (
        input  InValid, S, D, AReady, BReady,
        output InReady, AValid, A, BValid, B
`ifdef DEMUX_COUNT_EN
        , output CountA, CountB
`endif
    );

    // Producer and consumers side
    modport master (
        output InValid, S, D, AReady, BReady,
        input  InReady, AValid, A, BValid, B
`ifdef DEMUX_COUNT_EN
        , input CountA, CountB
`endif
    );
endinterface

// File: rtl/result_demux_1_to_2.sv
// Registered 1-to-2 result demux with per-channel valid/ready holding registers.
// Optional per-channel handshake counters enabled by DEMUX_COUNT_EN.
module result_demux_1_to_2 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    result_demux_1_to_2_if.slave   bus
);

    typedef enum logic {StEmpty = 1'b0, StFull = 1'b1} state_e;

    state_e           r_a_state, w_a_state_nxt;
    state_e           r_b_state, w_b_state_nxt;
    logic [WIDTH-1:0] r_a, r_b;
    logic             w_a_valid, w_b_valid;
    logic             w_in_ready;
    logic             w_acc_a, w_acc_b;
    logic             w_hs_a, w_hs_b;

    assign w_a_valid = (r_a_state == StFull);
    assign w_b_valid = (r_b_state == StFull);

    // Readiness looks only at the selected channel so a stalled peer never blocks it
    assign w_in_ready = bus.S ? (!w_b_valid || bus.BReady) : (!w_a_valid || bus.AReady);
    assign w_acc_a    = bus.InValid && w_in_ready && !bus.S;
    assign w_acc_b    = bus.InValid && w_in_ready &&  bus.S;
    assign w_hs_a     = w_a_valid && bus.AReady;
    assign w_hs_b     = w_b_valid && bus.BReady;

    always_comb begin
        w_a_state_nxt = r_a_state;
        unique case (r_a_state)
            StEmpty: if (w_acc_a)            w_a_state_nxt = StFull;
            StFull:  if (w_hs_a && !w_acc_a) w_a_state_nxt = StEmpty;
            default:                         w_a_state_nxt = StEmpty;
        endcase
    end

    always_comb begin
        w_b_state_nxt = r_b_state;
        unique case (r_b_state)
            StEmpty: if (w_acc_b)            w_b_state_nxt = StFull;
            StFull:  if (w_hs_b && !w_acc_b) w_b_state_nxt = StEmpty;
            default:                         w_b_state_nxt = StEmpty;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_state <= StEmpty;
            r_b_state <= StEmpty;
            r_a       <= '0;
            r_b       <= '0;
        end else begin
            r_a_state <= w_a_state_nxt;
            r_b_state <= w_b_state_nxt;
            if (w_acc_a) r_a <= bus.D;
            if (w_acc_b) r_b <= bus.D;
        end
    end

    assign bus.InReady = w_in_ready;
    assign bus.AValid  = w_a_valid;
    assign bus.BValid  = w_b_valid;
    assign bus.A       = r_a;
    assign bus.B       = r_b;

`ifdef DEMUX_COUNT_EN
    logic [WIDTH-1:0] r_count_a, r_count_b;

    // Wraps modulo 2^WIDTH
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count_a <= '0;
            r_count_b <= '0;
        end else begin
            if (w_hs_a) r_count_a <= r_count_a + 1'b1;
            if (w_hs_b) r_count_b <= r_count_b + 1'b1;
        end
    end

    assign bus.CountA = r_count_a;
    assign bus.CountB = r_count_b;
`endif

endmodule
